// File: rtl/lsu.sv
// Load/store unit: takes one core request at a time, checks alignment, drives a
// single-beat memory access with lane-shifted data and byte mask, and returns a
// sign/zero-extended load result or a trap (misaligned, illegal size, timeout).
module lsu #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_wen,
   input  logic [31:0]           i_req_addr,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_unsigned,
   input  logic [DATA_W-1:0]     i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_W-1:0]     o_rsp_rdata,
   output logic                  o_rsp_trap,
   output logic                  o_mem_req,
   input  logic                  i_mem_gnt,
   output logic [31:0]           o_mem_addr,
   output logic                  o_mem_wen,
   output logic [DATA_W-1:0]     o_mem_wdata,
   output logic [DATA_W/8-1:0]   o_mem_mask,
   input  logic                  i_mem_rvalid,
   input  logic [DATA_W-1:0]     i_mem_rdata
);

   localparam int MASK_W = DATA_W / 8;
   localparam int OFF_W  = (DATA_W == 64) ? 3 : 2;
   localparam logic [31:0] ALIGN_MASK = ~(32'(MASK_W) - 32'd1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_wen;
   logic [1:0]            r_size;
   logic                  r_unsigned;
   logic [OFF_W-1:0]      r_off;
   logic [31:0]           r_addr;
   logic [MASK_W-1:0]     r_mask;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_rdata;
   logic                  r_trap;
   logic [7:0]            r_cnt;

   logic                  w_req_trap;
   logic [OFF_W-1:0]      w_off;
   logic [8:0]            w_cnt_inc;
   logic                  w_timeout;

   // Misaligned accesses and doubles on a 32-bit bus are rejected up front.
   function automatic logic f_trap(input logic [1:0] size, input logic [2:0] a);
      logic t;
      case (size)
         2'd0:    t = 1'b0;
         2'd1:    t = a[0];
         2'd2:    t = |a[1:0];
         default: t = (DATA_W == 32) || (|a);
      endcase
      return t;
   endfunction

   // Byte-lane enables: 1, 2, 4 or 8 ones placed at the byte offset in the word.
   function automatic logic [MASK_W-1:0] f_mask(input logic [1:0] size,
                                                 input logic [OFF_W-1:0] off);
      logic [15:0] m;
      m = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
      return m[MASK_W-1:0];
   endfunction

   // Right-justify the addressed bytes, then extend from the access width.
   function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] word,
                                                   input logic [OFF_W-1:0] off,
                                                   input logic [1:0] size,
                                                   input logic uns);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] res;
      logic              sgn;
      int                nbits;
      sh    = word >> {off, 3'b000};
      nbits = 8 << size;
      case (size)
         2'd0:    sgn = sh[7];
         2'd1:    sgn = sh[15];
         default: sgn = sh[31];
      endcase
      sgn = sgn & ~uns;
      for (int i = 0; i < DATA_W; i++) begin
         res[i] = (i < nbits) ? sh[i] : sgn;
      end
      return res;
   endfunction

   assign w_off      = i_req_addr[OFF_W-1:0];
   assign w_req_trap = f_trap(i_req_size, i_req_addr[2:0]);
   assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
   assign w_timeout  = (w_cnt_inc == 9'(TIMEOUT));

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; read data wins over a timeout landing on the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_state_nxt = w_req_trap ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (i_mem_gnt) begin
               w_state_nxt = r_wen ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_mem_rvalid || w_timeout) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Request capture, wait counter and response data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wen      <= 1'b0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_off      <= '0;
         r_addr     <= '0;
         r_mask     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_trap     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_wen      <= i_req_wen;
                  r_size     <= i_req_size;
                  r_unsigned <= i_req_unsigned;
                  r_off      <= w_off;
                  r_addr     <= i_req_addr & ALIGN_MASK;
                  r_mask     <= f_mask(i_req_size, w_off);
                  r_wdata    <= i_req_wdata << {w_off, 3'b000};
                  r_rdata    <= '0;
                  r_trap     <= w_req_trap;
                  r_cnt      <= '0;
               end
            end
            S_REQ: begin
               if (i_mem_gnt && !r_wen) begin
                  r_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (i_mem_rvalid) begin
                  r_rdata <= f_extend(i_mem_rdata, r_off, r_size, r_unsigned);
                  r_trap  <= 1'b0;
               end else if (w_timeout) begin
                  r_rdata <= '0;
                  r_trap  <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc[7:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = (r_state == S_RESP);
   assign o_rsp_rdata = r_rdata;
   assign o_rsp_trap  = r_trap;
   assign o_mem_req   = (r_state == S_REQ);
   assign o_mem_wen   = (r_state == S_REQ) && r_wen;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_mem_mask  = r_mask;

endmodule
